fire_sched: RTL and testbench

//  Shot scheduler for the player bullet pool. Paces the fire rate, allocates a free bullet

---
 rtl/fire_sched.sv | 175 +++++++++++++++++
 tb/tb_fire_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_sched.sv
// Player shot scheduler: fire-rate pacing, round-robin bullet slot allocation and power-up timer.
// Define FIRE_SCHED_SHOT_CNT_EN to add the per-run shot counter output shot_cnt_o.
module fire_sched #(
  parameter int unsigned BULLET_NUM   = 8,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned FIRE_PERIOD  = 1000,
  parameter int unsigned PERIOD_W     = 10,
  parameter int unsigned POWER_CYCLES = 4096,
  parameter int unsigned POWER_W      = 12
) (
  input  logic                  clk_run,
  input  logic                  rst,
  input  logic                  game_run_i,
  input  logic                  pickup_double_i,
  input  logic [BULLET_NUM-1:0] slot_free_i,
  output logic                  shoot_o,
  output logic [IDX_W-1:0]      shoot_idx_o,
  output logic                  shoot_mode_o,
  output logic                  mode_o,
`ifdef FIRE_SCHED_SHOT_CNT_EN
  output logic [15:0]           shot_cnt_o,
`endif
  output logic                  stall_o
);

  localparam int unsigned SumW = IDX_W + 1;

  typedef enum logic [1:0] {StIdle, StArmed, StFire, StCooldown} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                shoot_q, shoot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                smode_q, smode_d;
  logic                stall_q, stall_d;
  logic [POWER_W-1:0]  timer_q, timer_d;
  logic                mode_q, mode_d;

  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [SumW-1:0]     cand;

  // First free slot scanning upward from ptr, wrapping at BULLET_NUM.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < BULLET_NUM; k++) begin
      cand = {1'b0, ptr_q} + SumW'(k);
      if (cand >= SumW'(BULLET_NUM)) begin
        cand = cand - SumW'(BULLET_NUM);
      end
      if (!sel_found && slot_free_i[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    shoot_d = 1'b0;
    idx_d   = idx_q;
    smode_d = smode_q;
    stall_d = 1'b0;

    // The slot has been handed to the pool once FIRE is reached, so advance regardless of run.
    if (state_q == StFire) begin
      ptr_d = (idx_q == IDX_W'(BULLET_NUM - 1)) ? '0 : idx_q + 1'b1;
    end

    if (!game_run_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (sel_found) begin
            state_d = StFire;
            shoot_d = 1'b1;
            idx_d   = sel_idx;
            smode_d = mode_q;
          end else begin
            stall_d = 1'b1;
          end
        end
        StFire: begin
          state_d = StCooldown;
          cnt_d   = PERIOD_W'(FIRE_PERIOD - 3);
        end
        StCooldown: begin
          if (cnt_q == '0) begin
            state_d = StArmed;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pickup beats expiry; the timer only runs while the game does.
  always_comb begin
    timer_d = timer_q;
    mode_d  = mode_q;
    if (pickup_double_i) begin
      timer_d = POWER_W'(POWER_CYCLES - 1);
      mode_d  = 1'b1;
    end else if (mode_q && game_run_i) begin
      if (timer_q == '0) begin
        mode_d = 1'b0;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      shoot_q <= 1'b0;
      idx_q   <= '0;
      smode_q <= 1'b0;
      stall_q <= 1'b0;
      timer_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      shoot_q <= shoot_d;
      idx_q   <= idx_d;
      smode_q <= smode_d;
      stall_q <= stall_d;
      timer_q <= timer_d;
      mode_q  <= mode_d;
    end
  end

  assign shoot_o      = shoot_q;
  assign shoot_idx_o  = idx_q;
  assign shoot_mode_o = smode_q;
  assign mode_o       = mode_q;
  assign stall_o      = stall_q;

`ifdef FIRE_SCHED_SHOT_CNT_EN
  logic [15:0] shot_cnt_q, shot_cnt_d;

  always_comb begin
    shot_cnt_d = shot_cnt_q;
    if (game_run_i && state_q == StIdle) begin
      shot_cnt_d = '0;
    end else if (shoot_d && shot_cnt_q != 16'hFFFF) begin
      shot_cnt_d = shot_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      shot_cnt_q <= '0;
    end else begin
      shot_cnt_q <= shot_cnt_d;
    end
  end

  assign shot_cnt_o = shot_cnt_q;
`endif

endmodule

// File: tb/tb_fire_sched.sv
// Self-checking bench for fire_sched: shot-schedule model compared every cycle plus directed pins.
module tb_fire_sched;

  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int FP    = 5;
  localparam int PW    = 2;
  localparam int PC    = 20;
  localparam int TW    = 5;

  logic          clk_run = 1'b0;
  logic          rst = 1'b0;
  logic          game_run = 1'b0;
  logic          pickup = 1'b0;
  logic [N-1:0]  slot_free = 4'hF;
  logic          shoot_o, shoot_mode_o, mode_o, stall_o;
  logic [IW-1:0] shoot_idx_o;
`ifdef FIRE_SCHED_SHOT_CNT_EN
  logic [15:0]   shot_cnt_o;
`endif

  fire_sched #(
    .BULLET_NUM  (N),
    .IDX_W       (IW),
    .FIRE_PERIOD (FP),
    .PERIOD_W    (PW),
    .POWER_CYCLES(PC),
    .POWER_W     (TW)
  ) dut (
    .clk_run        (clk_run),
    .rst            (rst),
    .game_run_i     (game_run),
    .pickup_double_i(pickup),
    .slot_free_i    (slot_free),
    .shoot_o        (shoot_o),
    .shoot_idx_o    (shoot_idx_o),
    .shoot_mode_o   (shoot_mode_o),
    .mode_o         (mode_o),
`ifdef FIRE_SCHED_SHOT_CNT_EN
    .shot_cnt_o     (shot_cnt_o),
`endif
    .stall_o        (stall_o)
  );

  always #5 clk_run = ~clk_run;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_run) cyc <= cyc + 1;

  // Behavioural model: a shot is allowed once FP edges have passed since the previous one
  // (or one edge after the run starts); when allowed and no slot is free, the scheduler stalls.
  bit m_idle, m_found, m_mode, exp_shoot, exp_stall, exp_smode, cmp_en;
  int m_hold, m_ptr, m_timer, m_sel, exp_idx;

  always @(posedge clk_run or posedge rst) begin
    if (rst) begin
      m_idle = 1; m_hold = 0; m_ptr = 0; m_timer = 0; m_mode = 0;
      exp_shoot = 0; exp_stall = 0; exp_idx = 0; exp_smode = 0;
    end else begin
      exp_shoot = 0;
      exp_stall = 0;
      if (!game_run) begin
        m_idle = 1;
      end else if (m_idle) begin
        m_idle = 0;
        m_hold = 0;
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        m_found = 0;
        m_sel   = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_found && slot_free[(m_ptr + k) % N]) begin
            m_found = 1;
            m_sel   = (m_ptr + k) % N;
          end
        end
        if (m_found) begin
          exp_shoot = 1;
          exp_idx   = m_sel;
          exp_smode = m_mode;
          m_ptr     = (m_sel + 1) % N;
          m_hold    = FP - 1;
        end else begin
          exp_stall = 1;
        end
      end
      if (pickup) begin
        m_timer = PC - 1;
        m_mode  = 1;
      end else if (m_mode && game_run) begin
        if (m_timer == 0) m_mode = 0;
        else m_timer--;
      end
    end
  end

  always @(negedge clk_run) begin
    if (cmp_en) begin
      check("shoot", shoot_o, exp_shoot);
      check("stall", stall_o, exp_stall);
      check("mode", mode_o, m_mode);
      if (exp_shoot) begin
        check("shoot_idx", shoot_idx_o, exp_idx);
        check("shoot_mode", shoot_mode_o, exp_smode);
      end
    end
  end

  typedef struct {int t; int idx; bit mode;} shot_t;
  shot_t shots[$];
  always @(negedge clk_run) begin
    if (shoot_o) shots.push_back('{t: cyc, idx: int'(shoot_idx_o), mode: shoot_mode_o});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_run);
    #2;
  endtask

  task automatic wait_shot(input string name);
    int i;
    i = 0;
    while (!shoot_o && i < 30) begin
      @(negedge clk_run);
      i++;
    end
    check(name, shoot_o, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t required < 100000", $time);
    $fatal(1);
  end

  int e0, pm, q, n0, c0, c1;
  initial begin
    #1 rst = 1'b1;
    tick(1);
    cmp_en = 1;
    check("rst_shoot", shoot_o, 0);
    check("rst_idx", shoot_idx_o, 0);
    check("rst_smode", shoot_mode_o, 0);
    check("rst_mode", mode_o, 0);
    check("rst_stall", stall_o, 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // 1: all slots free, five shots paced FP apart, round-robin idx
    shots.delete();
    e0 = cyc;
    game_run = 1'b1;
    tick(23);
    check("t1_count", shots.size(), 5);
    for (int i = 0; i < 5 && i < shots.size(); i++) begin
      check("t1_time", shots[i].t - e0, 2 + 5 * i);
      check("t1_idx", shots[i].idx, i % 4);
    end

    // 2: sparse slots, then starvation and recovery
    game_run = 1'b0;
    tick(2);
    shots.delete();
    slot_free = 4'b1010;
    game_run = 1'b1;
    e0 = cyc;
    tick(18);
    check("t2_count", shots.size(), 4);
    for (int i = 0; i < 4 && i < shots.size(); i++) begin
      check("t2_idx", shots[i].idx, (i % 2 == 0) ? 1 : 3);
    end
    slot_free = 4'b0000;
    tick(4);
    for (int i = 0; i < 6; i++) begin
      check("t2_stall", stall_o, 1);
      check("t2_noshot", shoot_o, 0);
      tick(1);
    end
    check("t2_count_stalled", shots.size(), 4);
    slot_free = 4'b0100;
    tick(1);
    check("t2_resume_shoot", shoot_o, 1);
    check("t2_resume_idx", shoot_idx_o, 2);
    check("t2_resume_stall", stall_o, 0);

    // 3: pickup, 20-cycle double mode, shots in the window carry mode 1
    game_run = 1'b0;
    tick(2);
    slot_free = 4'hF;
    game_run = 1'b1;
    tick(3);
    shots.delete();
    pm = cyc;
    pickup = 1'b1;
    tick(1);
    pickup = 1'b0;
    check("t3_mode_rise", mode_o, 1);
    tick(19);
    check("t3_mode_hold", mode_o, 1);
    tick(1);
    check("t3_mode_fall", mode_o, 0);
    c0 = 0; c1 = 0;
    foreach (shots[i]) begin
      if (shots[i].t >= pm + 2 && shots[i].t <= pm + 21) begin
        if (shots[i].mode) c1++;
        else c0++;
      end
    end
    check("t3_window_single", c0, 0);
    check("t3_window_double", c1, 4);

    // 4: reload exactly at expiry, then freeze while the game is paused
    pickup = 1'b1;
    tick(1);
    pickup = 1'b0;
    tick(19);
    pickup = 1'b1;
    tick(1);
    pickup = 1'b0;
    check("t4_reload_keep", mode_o, 1);
    tick(19);
    check("t4_reload_hold", mode_o, 1);
    tick(1);
    check("t4_reload_fall", mode_o, 0);
    q = cyc;
    pickup = 1'b1;
    tick(1);
    pickup = 1'b0;
    tick(4);
    game_run = 1'b0;
    tick(8);
    game_run = 1'b1;
    tick(15);
    check("t4_freeze_hold", mode_o, 1);
    tick(1);
    check("t4_freeze_fall", mode_o, 0);

    // 5: stop during FIRE, then reset mid-cooldown with a live power-up
    wait_shot("t5_first_shot");
    @(negedge clk_run);
    wait_shot("t5_fire_seen");
    game_run = 1'b0;
    #1 n0 = shots.size();
    repeat (10) @(negedge clk_run);
    #1 check("t5_no_shot_after_stop", shots.size() - n0, 0);
    game_run = 1'b1;
    pickup = 1'b1;
    @(negedge clk_run);
    #1 pickup = 1'b0;
    wait_shot("t5_shot_before_rst");
    check("t5_shot_mode_double", shoot_mode_o, 1);
    tick(2);
    rst = 1'b1;
    #1;
    check("t5_rst_shoot", shoot_o, 0);
    check("t5_rst_idx", shoot_idx_o, 0);
    check("t5_rst_smode", shoot_mode_o, 0);
    check("t5_rst_mode", mode_o, 0);
    check("t5_rst_stall", stall_o, 0);
    tick(1);
    rst = 1'b0;
    wait_shot("t5_shot_after_rst");
    check("t5_idx_after_rst", shoot_idx_o, 0);
    check("t5_mode_after_rst", shoot_mode_o, 0);

`ifdef FIRE_SCHED_SHOT_CNT_EN
    // 6: per-run shot counter
    game_run = 1'b0;
    tick(2);
    game_run = 1'b1;
    tick(12);
    check("t6_cnt_three", shot_cnt_o, 3);
    game_run = 1'b0;
    tick(2);
    game_run = 1'b1;
    tick(1);
    check("t6_cnt_cleared", shot_cnt_o, 0);
`endif

    game_run = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
